tdr_dyn_ctrl: RTL

// Sequencer for a bank of dynamic time-redundant flip-flop cells.
// - Drives the shared modeS (image save) and fetchA (fast fetch / recovery) controls of all cells.
// - Collects the cells' voter fail flags and runs the recovery sequence.
// - Counts errors and declares a permanent fault when too many errors fall within one time window.

---
 rtl/tdr_dyn_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/tdr_dyn_ctrl.sv
// Sequencer for a bank of dynamic time-redundant flip-flop cells: drives the shared
// image-save / fast-fetch controls, runs recovery on voter fails and tracks error density.
module tdr_dyn_ctrl #(
  parameter int N_FF     = 8,
  parameter int SAVE_CYC = 3,
  parameter int REC_CYC  = 2,
  parameter int ERR_MAX  = 3,
  parameter int WIN_LEN  = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               save_req,
  input  logic [N_FF-1:0]                    fail_vec,
  output logic                               modeS,
  output logic                               fetchA,
  output logic [1:0]                         phase,
  output logic                               busy,
  output logic                               fail_any,
  output logic [$clog2(ERR_MAX+1)-1:0]       err_cnt,
  output logic                               save_done,
  output logic                               perm_fault,
  output logic [1:0]                         state_dbg
);

  localparam int EW   = $clog2(ERR_MAX + 1);
  localparam int WW   = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam int TMAX = (SAVE_CYC > REC_CYC) ? SAVE_CYC : REC_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [EW-1:0] ERR_TOP   = EW'(ERR_MAX);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_LEN - 1);
  localparam logic [TW-1:0] SAVE_LAST = TW'(SAVE_CYC - 1);
  localparam logic [TW-1:0] REC_LAST  = TW'(REC_CYC - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SAVE    = 2'd1,
    RECOVER = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t        state;
  logic          pending;
  logic [WW-1:0] win_cnt;
  logic [TW-1:0] tmr;

  logic          fail_seen;
  logic          wrap;
  logic [EW-1:0] err_base;
  logic [EW-1:0] err_inc;
  logic          save_go;

  assign modeS     = (state == SAVE);
  assign fetchA    = (state == RECOVER);
  assign busy      = (state != RUN);
  assign state_dbg = state;

  // The window clear is applied before a coinciding recovery increment.
  always_comb begin
    fail_seen = |fail_vec;
    wrap      = (state != HALT) && (win_cnt == WIN_LAST);
    err_base  = wrap ? '0 : err_cnt;
    err_inc   = (err_base == ERR_TOP) ? err_base : err_base + EW'(1);
    save_go   = (pending | save_req) && (phase == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      phase      <= 2'd0;
      pending    <= 1'b0;
      win_cnt    <= '0;
      tmr        <= '0;
      fail_any   <= 1'b0;
      err_cnt    <= '0;
      save_done  <= 1'b0;
      perm_fault <= 1'b0;
    end else begin
      fail_any  <= fail_seen;
      save_done <= 1'b0;
      if (state != HALT) begin
        win_cnt <= wrap ? '0 : win_cnt + WW'(1);
        err_cnt <= err_base;
        phase   <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        pending <= pending | save_req;
      end
      case (state)
        RUN: begin
          if (fail_seen) begin
            state   <= RECOVER;
            tmr     <= '0;
            err_cnt <= err_inc;
          end else if (save_go) begin
            state   <= SAVE;
            tmr     <= '0;
            pending <= 1'b0;
          end
        end
        SAVE: begin
          if (tmr == SAVE_LAST) begin
            state     <= RUN;
            save_done <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        RECOVER: begin
          if (tmr == REC_LAST) begin
            if (err_cnt == ERR_TOP) begin
              state      <= HALT;
              phase      <= 2'd0;
              perm_fault <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
